// File: rtl/rf_fetch_pipe.sv
// Register-fetch stage: register file, EX/MEM/WB operand forwarding, load-use bubbles and a
// valid/ready RF/EX pipeline register. Define RF_FETCH_STALL_CNT_EN to add the stall_count output.
module rf_fetch_pipe #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ZERO_REG = 31,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_ra,
  input  logic [AW-1:0]   in_rb,
  input  logic [AW-1:0]   in_rd,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_is_load,
  input  logic            in_wr,
  input  logic            ex_fwd_en,
  input  logic [AW-1:0]   ex_fwd_rd,
  input  logic [XLEN-1:0] ex_fwd_data,
  input  logic            mem_fwd_en,
  input  logic [AW-1:0]   mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [XLEN-1:0] out_imm,
  output logic [AW-1:0]   out_rd,
  output logic            out_is_load,
  output logic            out_wr
`ifdef RF_FETCH_STALL_CNT_EN
  ,
  output logic [31:0]     stall_count
`endif
);

  localparam logic [AW-1:0] ZeroIdx = AW'(ZERO_REG);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [AW-1:0]   src    [2];
  logic [XLEN-1:0] opnd   [2];
  logic            hazard;
  logic            advance;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en && wb_rd != ZeroIdx) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  assign src[0] = in_ra;
  assign src[1] = in_rb;

  // Youngest producer wins; WB is a write-through bypass of the same-cycle write.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (src[i] == ZeroIdx) begin
        opnd[i] = '0;
      end else if (ex_fwd_en && ex_fwd_rd == src[i]) begin
        opnd[i] = ex_fwd_data;
      end else if (mem_fwd_en && mem_fwd_rd == src[i]) begin
        opnd[i] = mem_fwd_data;
      end else if (wb_en && wb_rd == src[i]) begin
        opnd[i] = wb_data;
      end else begin
        opnd[i] = regs_q[src[i]];
      end
    end
  end

  // Load data is not available until MEM, so a dependent instruction waits one cycle.
  assign hazard = in_valid && out_valid && out_is_load && out_wr && (out_rd != ZeroIdx) &&
                  (out_rd == in_ra || out_rd == in_rb);
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !hazard;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_is_load <= 1'b0;
      out_wr      <= 1'b0;
    end else if (advance) begin
      if (in_valid && !hazard) begin
        out_valid   <= 1'b1;
        out_a       <= opnd[0];
        out_b       <= opnd[1];
        out_imm     <= in_imm;
        out_rd      <= in_rd;
        out_is_load <= in_is_load;
        out_wr      <= in_wr;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RF_FETCH_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (hazard && advance && stall_count != 32'hFFFF_FFFF) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_fetch_pipe.sv
// Randomized and directed bench for rf_fetch_pipe against a behavioural model of the stage.
module tb_rf_fetch_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_ra, in_rb, in_rd;
  logic [63:0] in_imm;
  logic        in_is_load, in_wr;
  logic        ex_fwd_en, mem_fwd_en, wb_en;
  logic [4:0]  ex_fwd_rd, mem_fwd_rd, wb_rd;
  logic [63:0] ex_fwd_data, mem_fwd_data, wb_data;
  logic        out_valid, out_ready;
  logic [63:0] out_a, out_b, out_imm;
  logic [4:0]  out_rd;
  logic        out_is_load, out_wr;
`ifdef RF_FETCH_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic [63:0] m_rf [32];
  logic        m_valid, m_load, m_wr;
  logic [63:0] m_a, m_b, m_imm;
  logic [4:0]  m_rd;
  logic [31:0] m_stall;

  rf_fetch_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .in_imm(in_imm),
    .in_is_load(in_is_load), .in_wr(in_wr),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_rd(out_rd),
    .out_is_load(out_is_load), .out_wr(out_wr)
`ifdef RF_FETCH_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_resolve(input logic [4:0] s);
    if (s == 5'd31) return 64'd0;
    if (ex_fwd_en && ex_fwd_rd == s) return ex_fwd_data;
    if (mem_fwd_en && mem_fwd_rd == s) return mem_fwd_data;
    if (wb_en && wb_rd == s) return wb_data;
    return m_rf[s];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
    m_valid = 0; m_load = 0; m_wr = 0;
    m_a = 0; m_b = 0; m_imm = 0; m_rd = 0; m_stall = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_a", out_a, m_a);
    check("out_b", out_b, m_b);
    check("out_imm", out_imm, m_imm);
    check("out_rd", 64'(out_rd), 64'(m_rd));
    check("out_is_load", 64'(out_is_load), 64'(m_load));
    check("out_wr", 64'(out_wr), 64'(m_wr));
`ifdef RF_FETCH_STALL_CNT_EN
    check("stall_count", 64'(stall_count), 64'(m_stall));
`endif
  endtask

  task automatic drive_idle();
    in_valid = 0; in_ra = 0; in_rb = 0; in_rd = 0; in_imm = 0; in_is_load = 0; in_wr = 0;
    ex_fwd_en = 0; ex_fwd_rd = 0; ex_fwd_data = 0;
    mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0;
    out_ready = 1;
  endtask

  // Inputs are set just after a rising edge; this checks in_ready, clocks, then checks outputs.
  task automatic cycle();
    logic hz, adv;
    logic [63:0] ra_v, rb_v;
    #2;
    hz = in_valid && m_valid && m_load && m_wr && m_rd != 5'd31 &&
         (m_rd == in_ra || m_rd == in_rb);
    adv = !m_valid || out_ready;
    check("in_ready", 64'(in_ready), 64'(adv && !hz));
    ra_v = m_resolve(in_ra);
    rb_v = m_resolve(in_rb);
    @(posedge clk);
    if (adv) begin
      if (in_valid && !hz) begin
        m_valid = 1; m_a = ra_v; m_b = rb_v; m_imm = in_imm;
        m_rd = in_rd; m_load = in_is_load; m_wr = in_wr;
      end else begin
        m_valid = 0;
      end
      if (hz && m_stall != 32'hFFFF_FFFF) m_stall++;
    end
    if (wb_en && wb_rd != 5'd31) m_rf[wb_rd] = wb_data;
    #1;
    check_outputs();
  endtask

  function automatic logic [4:0] rand_idx();
    return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
  endfunction

  task automatic drive_random();
    in_valid = ($urandom_range(0, 3) != 0);
    in_ra = rand_idx(); in_rb = rand_idx(); in_rd = rand_idx();
    in_imm = {$urandom, $urandom};
    in_is_load = $urandom_range(0, 1) == 1;
    in_wr = ($urandom_range(0, 3) != 0);
    ex_fwd_en = $urandom_range(0, 2) == 0;  ex_fwd_rd = rand_idx();  ex_fwd_data = {$urandom, $urandom};
    mem_fwd_en = $urandom_range(0, 2) == 0; mem_fwd_rd = rand_idx(); mem_fwd_data = {$urandom, $urandom};
    wb_en = $urandom_range(0, 1) == 1;      wb_rd = rand_idx();      wb_data = {$urandom, $urandom};
    out_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    logic [63:0] held_imm;
    reset = 1;
    drive_idle();
    model_clear();
    #1;
    check_outputs();
    @(posedge clk);
    #1 reset = 0;

    // Read of R5 straight after reset
    in_valid = 1; in_ra = 5;
    cycle();
    check("r5_after_reset", out_a, 64'd0);

    // Write-through bypass, then read from the file
    drive_idle(); in_valid = 1; in_ra = 3; wb_en = 1; wb_rd = 3; wb_data = 64'hAA;
    cycle();
    check("wb_bypass", out_a, 64'hAA);
    drive_idle(); in_valid = 1; in_ra = 3;
    cycle();
    check("rf_read", out_a, 64'hAA);

    // Forwarding priority EX > MEM > WB
    drive_idle(); in_valid = 1; in_rb = 2;
    ex_fwd_en = 1; ex_fwd_rd = 2; ex_fwd_data = 64'h11;
    mem_fwd_en = 1; mem_fwd_rd = 2; mem_fwd_data = 64'h22;
    wb_en = 1; wb_rd = 2; wb_data = 64'h33;
    cycle();
    check("prio_ex", out_b, 64'h11);
    ex_fwd_en = 0;
    cycle();
    check("prio_mem", out_b, 64'h22);
    mem_fwd_en = 0;
    cycle();
    check("prio_wb", out_b, 64'h33);

    // Zero register ignores writes and forwarding
    drive_idle(); wb_en = 1; wb_rd = 31; wb_data = 64'hFF;
    cycle();
    drive_idle(); in_valid = 1; in_ra = 31; ex_fwd_en = 1; ex_fwd_rd = 31; ex_fwd_data = 64'h5;
    cycle();
    check("zero_reg", out_a, 64'd0);

    // Load-use: one bubble, then operand from MEM forwarding
    drive_idle(); in_valid = 1; in_is_load = 1; in_wr = 1; in_rd = 4;
    cycle();
    drive_idle(); in_valid = 1; in_ra = 4; in_rd = 6; in_wr = 1;
    #1 check("hazard_in_ready", 64'(in_ready), 64'd0);
    cycle();
    check("bubble_valid", 64'(out_valid), 64'd0);
    mem_fwd_en = 1; mem_fwd_rd = 4; mem_fwd_data = 64'h77;
    cycle();
    check("load_use_fwd", out_a, 64'h77);
    check("load_use_valid", 64'(out_valid), 64'd1);

    // Backpressure: hold three cycles, then release
    drive_idle(); in_valid = 1; in_imm = 64'h1234; out_ready = 0;
    held_imm = out_imm;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_hold_imm", out_imm, held_imm);
    end
    out_ready = 1;
    cycle();
    check("bp_release_imm", out_imm, 64'h1234);
    in_valid = 0;
    cycle();
    check("bp_no_dup", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-transfer
    drive_idle(); in_valid = 1; in_imm = 64'hBEEF; in_rd = 7; in_wr = 1;
    wb_en = 1; wb_rd = 9; wb_data = 64'hCAFE;
    cycle();
    #2 reset = 1;
    #1;
    model_clear();
    check_outputs();
    @(posedge clk);
    #1 reset = 0;
    drive_idle(); in_valid = 1; in_ra = 9; in_rb = 3;
    cycle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      drive_random();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
